// File: rtl/fpalign.sv
// Exponent-alignment stage for IEEE-754 single add: captures an operand pair,
// then right-shifts the smaller-exponent mantissa STEP bits per cycle.
module fpalign #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        alessb,
  output logic [23:0] manta,
  output logic [23:0] mantb,
  output logic [23:0] shmant,
  output logic [7:0]  exp_pre
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [7:0] STEP_W = 8'(STEP);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  remaining;

  logic [7:0]  exp_a;
  logic [7:0]  exp_b;
  logic        a_lt_b;
  logic [7:0]  diff;
  logic [23:0] mant_a_in;
  logic [23:0] mant_b_in;
  logic [23:0] src_mant;
  logic [7:0]  step_amt;
  logic [7:0]  rem_after;

  // Sign bits play no part in alignment.
  logic unused_signs;
  assign unused_signs = op_a[31] ^ op_b[31];

  always_comb begin
    exp_a     = op_a[30:23];
    exp_b     = op_b[30:23];
    a_lt_b    = (exp_a < exp_b);
    diff      = a_lt_b ? (exp_b - exp_a) : (exp_a - exp_b);
    mant_a_in = {1'b1, op_a[22:0]};
    mant_b_in = {1'b1, op_b[22:0]};
    src_mant  = a_lt_b ? mant_a_in : mant_b_in;
    step_amt  = (remaining < STEP_W) ? remaining : STEP_W;
    rem_after = remaining - step_amt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = (diff != 8'd0 && diff < 8'd24) ? SHIFT : DONE;
      SHIFT: if (rem_after == 8'd0) state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: the datapath is cleared on reset because its contents are visible on
  // the outputs; nothing here is a memory array, so clearing is cheap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      remaining <= 8'd0;
      alessb    <= 1'b0;
      manta     <= 24'd0;
      mantb     <= 24'd0;
      shmant    <= 24'd0;
      exp_pre   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            alessb    <= a_lt_b;
            manta     <= mant_a_in;
            mantb     <= mant_b_in;
            exp_pre   <= a_lt_b ? exp_b : exp_a;
            remaining <= diff;
            shmant    <= (diff >= 8'd24) ? 24'd0 : src_mant;
          end
        end
        SHIFT: begin
          // Truncating shift: bits leaving the LSB are dropped, no sticky.
          shmant    <= shmant >> step_amt;
          remaining <= rem_after;
        end
        default: ;
      endcase
    end
  end

  // reset_n gating keeps the handshake quiet for the whole reset window.
  assign in_ready  = reset_n && (state == IDLE);
  assign out_valid = reset_n && (state == DONE);

endmodule

// File: tb/tb_fpalign.sv
// Self-checking bench for fpalign: STEP=1 and STEP=4 instances share stimulus;
// expected results come from a direct-shift model through per-DUT scoreboards.
module tb_fpalign;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;

  logic        in_ready1, out_valid1, alessb1;
  logic [23:0] manta1, mantb1, shmant1;
  logic [7:0]  exp_pre1;
  logic        in_ready4, out_valid4, alessb4;
  logic [23:0] manta4, mantb4, shmant4;
  logic [7:0]  exp_pre4;

  always #5 clk = ~clk;

  fpalign #(.STEP(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid1), .out_ready(out_ready),
    .alessb(alessb1), .manta(manta1), .mantb(mantb1), .shmant(shmant1),
    .exp_pre(exp_pre1)
  );

  fpalign #(.STEP(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid4), .out_ready(out_ready),
    .alessb(alessb4), .manta(manta4), .mantb(mantb4), .shmant(shmant4),
    .exp_pre(exp_pre4)
  );

  typedef struct {
    logic        alessb;
    logic [23:0] manta;
    logic [23:0] mantb;
    logic [23:0] shmant;
    logic [7:0]  exp_pre;
    int          lat;
  } exp_t;

  exp_t sb1[$];
  exp_t sb4[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int step);
    exp_t        m;
    logic [7:0]  ea = a[30:23];
    logic [7:0]  eb = b[30:23];
    int          d;
    logic [23:0] src;
    m.alessb  = (ea < eb);
    m.exp_pre = m.alessb ? eb : ea;
    d         = m.alessb ? (int'(eb) - int'(ea)) : (int'(ea) - int'(eb));
    m.manta   = {1'b1, a[22:0]};
    m.mantb   = {1'b1, b[22:0]};
    src       = m.alessb ? m.manta : m.mantb;
    m.shmant  = (d >= 24) ? 24'd0 : (src >> d);
    m.lat     = (d == 0 || d >= 24) ? 1 : 1 + (d + step - 1) / step;
    return m;
  endfunction

  task automatic chk_out(input string pfx, input logic al, input logic [23:0] ma,
                         input logic [23:0] mb, input logic [23:0] sh,
                         input logic [7:0] ep, input exp_t e);
    check({pfx, "_alessb"}, 32'(al), 32'(e.alessb));
    check({pfx, "_manta"},  32'(ma), 32'(e.manta));
    check({pfx, "_mantb"},  32'(mb), 32'(e.mantb));
    check({pfx, "_shmant"}, 32'(sh), 32'(e.shmant));
    check({pfx, "_exp_pre"}, 32'(ep), 32'(e.exp_pre));
  endtask

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready1 && in_ready4;
    end
    check("ready_timeout", {30'd0, in_ready1, in_ready4}, 32'd3);
  endtask

  // Offers one pair, then tracks both DUTs until each has produced its result.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit   got1 = 1'b0;
    bit   got4 = 1'b0;
    wait_ready();
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    sb1.push_back(model(a, b, 1));
    sb4.push_back(model(a, b, 4));
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 1; n <= 40 && !(got1 && got4); n++) begin
      if (out_valid1 && !got1) begin
        got1 = 1'b1;
        e = sb1.pop_front();
        chk_out({tag, "_s1"}, alessb1, manta1, mantb1, shmant1, exp_pre1, e);
        check({tag, "_s1_lat"}, 32'(n), 32'(e.lat));
      end
      if (out_valid4 && !got4) begin
        got4 = 1'b1;
        e = sb4.pop_front();
        chk_out({tag, "_s4"}, alessb4, manta4, mantb4, shmant4, exp_pre4, e);
        check({tag, "_s4_lat"}, 32'(n), 32'(e.lat));
      end
      if (!(got1 && got4)) @(negedge clk);
    end
    check({tag, "_done"}, {30'd0, got1, got4}, 32'd3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op_a      = 32'd0;
    op_b      = 32'd0;

    // Reset state, observed while reset is still asserted.
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(in_ready1 | in_ready4), 32'd0);
    check("rst_out_valid", 32'(out_valid1 | out_valid4), 32'd0);
    check("rst_shmant",    32'(shmant1), 32'd0);
    check("rst_exp_pre",   32'(exp_pre1), 32'd0);
    reset_n = 1'b1;
    #1;
    check("rel_in_ready", {30'd0, in_ready1, in_ready4}, 32'd3);

    // Directed cases, including the shift-limit boundaries.
    run_op("eq_exp",   32'h3F800000, 32'h3F800000);
    run_op("a_larger", 32'h40000000, 32'h3F800000);
    run_op("b_d3",     32'h3F800000, 32'h41000000);
    run_op("d24",      32'h4B800000, 32'h3F800000);
    run_op("d23",      32'h4B000000, 32'h3F800000);
    run_op("d25_b",    32'h3F800000, 32'h4C000000);
    run_op("frac_d2",  32'h40C00000, 32'h3FA00000);
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("rnd%0d", i),
             {1'b0, 8'(100 + $urandom_range(0, 40)), 23'($urandom)},
             {1'b0, 8'(100 + $urandom_range(0, 40)), 23'($urandom)});
    end

    // Backpressure: result must hold and new offers must be ignored in DONE.
    wait_ready();
    op_a      = 32'h3F800000;
    op_b      = 32'h3F800000;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    e = model(32'h3F800000, 32'h3F800000, 1);
    @(negedge clk);
    op_a = 32'h40000000;
    op_b = 32'h40000000;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {30'd0, out_valid1, out_valid4}, 32'd3);
      check("bp_in_ready",  32'(in_ready1 | in_ready4), 32'd0);
      check("bp_shmant",    32'(shmant1), 32'(e.shmant));
      check("bp_exp_pre",   32'(exp_pre1), 32'(e.exp_pre));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_out_valid", 32'(out_valid1 | out_valid4), 32'd0);
    check("bp_hs_in_ready",  {30'd0, in_ready1, in_ready4}, 32'd3);
    check("bp_hs_exp_pre",   32'(exp_pre1), 32'h7F);
    @(negedge clk);
    in_valid = 1'b0;
    e = model(32'h40000000, 32'h40000000, 1);
    check("bp_next_out_valid", {30'd0, out_valid1, out_valid4}, 32'd3);
    chk_out("bp_next", alessb1, manta1, mantb1, shmant1, exp_pre1, e);

    // Reset in the middle of a d=10 shift.
    wait_ready();
    op_a     = 32'h44800000;
    op_b     = 32'h3F800000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_busy", 32'(out_valid1 | in_ready1 | in_ready4), 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_flags",  32'(in_ready1 | in_ready4 | out_valid1 | out_valid4), 32'd0);
    check("mid_rst_manta",  32'(manta1 | manta4), 32'd0);
    check("mid_rst_mantb",  32'(mantb1 | mantb4), 32'd0);
    check("mid_rst_shmant", 32'(shmant1 | shmant4), 32'd0);
    check("mid_rst_exp",    32'(exp_pre1 | exp_pre4), 32'd0);
    check("mid_rst_alessb", 32'(alessb1 | alessb4), 32'd0);
    reset_n = 1'b1;
    #1;
    check("mid_rel_in_ready", {30'd0, in_ready1, in_ready4}, 32'd3);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("mid_no_out_valid", 32'(out_valid1 | out_valid4), 32'd0);
    end
    run_op("post_rst", 32'h3F800000, 32'h41000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
